fp_div_status_stage: RTL and testbench

//  Registered output stage directly downstream of the combinational single-precision divider DIV.

---
 rtl/fp32_pkg.sv | 75 +++++++
 rtl/fp_skid_fifo2.sv | 59 +++++
 rtl/fp_div_status_stage.sv | 86 ++++++++
 tb/tb_fp_div_status_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Single-precision field slices, classifiers and the bit positions used by
// the divider status stage for its class and flag vectors.
package fp32_pkg;

  localparam logic [31:0] QNAN_CANON = 32'h7FC0_0000;

  // out_class one-hot bit positions: {nan,inf,normal,subnormal,zero}
  localparam int CLS_W    = 5;
  localparam int CLS_ZERO = 0;
  localparam int CLS_SUB  = 1;
  localparam int CLS_NORM = 2;
  localparam int CLS_INF  = 3;
  localparam int CLS_NAN  = 4;

  // status flag bit positions: {NV,DZ,OF,UF}
  localparam int FLG_W  = 4;
  localparam int FLG_UF = 0;
  localparam int FLG_OF = 1;
  localparam int FLG_DZ = 2;
  localparam int FLG_NV = 3;

  typedef struct packed {
    logic [31:0]      data;
    logic [CLS_W-1:0] cls;
    logic [FLG_W-1:0] flags;
  } res_t;

  localparam int RES_W = $bits(res_t);

  function automatic logic [7:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] fp_man(input logic [31:0] x);
    return x[22:0];
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    return (fp_exp(x) == 8'h00) && (fp_man(x) == 23'd0);
  endfunction

  function automatic logic is_sub(input logic [31:0] x);
    return (fp_exp(x) == 8'h00) && (fp_man(x) != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (fp_exp(x) == 8'hFF) && (fp_man(x) == 23'd0);
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (fp_exp(x) == 8'hFF) && (fp_man(x) != 23'd0);
  endfunction

  // Signalling NaN: quiet bit (mantissa MSB) clear
  function automatic logic is_snan(input logic [31:0] x);
    return is_nan(x) && !x[22];
  endfunction

  function automatic logic is_finite(input logic [31:0] x);
    return fp_exp(x) != 8'hFF;
  endfunction

  // Exactly one bit set for any encoding
  function automatic logic [CLS_W-1:0] classify(input logic [31:0] x);
    logic [CLS_W-1:0] c;
    c           = '0;
    c[CLS_ZERO] = is_zero(x);
    c[CLS_SUB]  = is_sub(x);
    c[CLS_INF]  = is_inf(x);
    c[CLS_NAN]  = is_nan(x);
    c[CLS_NORM] = (fp_exp(x) != 8'h00) && (fp_exp(x) != 8'hFF);
    return c;
  endfunction

endpackage

// File: rtl/fp_skid_fifo2.sv
// Two-entry FIFO with a registered ready. The head entry drives the output
// directly, so an item pushed into an empty FIFO is visible one cycle later
// and stays put while the consumer stalls.
module fp_skid_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic [1:0]       cnt_nxt;
  logic             rdy_q;
  logic             push;
  logic             pop;

  assign push      = in_valid && rdy_q;
  assign pop       = (cnt != 2'd0) && out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = mem[rd_ptr];

  // Occupancy after this cycle's push/pop; push+pop at count 1 keeps it at 1
  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + 2'd1;
    else if (!push && pop) cnt_nxt = cnt - 2'd1;
  end

  // Storage, pointers, and ready registered from next-cycle occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      rdy_q  <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt   <= cnt_nxt;
      rdy_q <= (cnt_nxt != 2'd2);
    end
  end

endmodule

// File: rtl/fp_div_status_stage.sv
// Registered status stage behind the combinational fp32 divider: classifies
// the quotient, optionally canonicalises NaNs, derives per-result IEEE flags,
// accumulates sticky flags and counts accepted results.
module fp_div_status_stage
  import fp32_pkg::*;
#(
  parameter bit CANON_NAN = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in1,
  input  logic [31:0]      in2,
  input  logic [31:0]      div_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CLS_W-1:0] out_class,
  output logic [FLG_W-1:0] out_flags,
  output logic [FLG_W-1:0] sticky,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] res_cnt
);

  res_t             res_in;
  res_t             res_out;
  logic [FLG_W-1:0] flg;
  logic [31:0]      data_c;
  logic             acc;

  assign acc = in_valid && in_ready;

  // Flags come from the operands and raw quotient; class from the emitted data
  always_comb begin
    flg         = '0;
    flg[FLG_NV] = (is_zero(in1) && is_zero(in2)) ||
                  (is_inf(in1)  && is_inf(in2))  ||
                  is_snan(in1) || is_snan(in2);
    flg[FLG_DZ] = is_zero(in2) && is_finite(in1) && !is_zero(in1);
    flg[FLG_OF] = is_inf(div_out) && is_finite(in1) && is_finite(in2) && !is_zero(in2);
    flg[FLG_UF] = (is_zero(div_out) || is_sub(div_out)) &&
                  is_finite(in1) && !is_zero(in1) && is_finite(in2);

    data_c = (CANON_NAN && is_nan(div_out)) ? QNAN_CANON : div_out;

    res_in       = '0;
    res_in.data  = data_c;
    res_in.cls   = classify(data_c);
    res_in.flags = flg;
  end

  fp_skid_fifo2 #(
    .WIDTH (RES_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (res_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (res_out)
  );

  assign out_data  = res_out.data;
  assign out_class = res_out.cls;
  assign out_flags = res_out.flags;

  // Sticky flags and result count advance on accept; a clear in the same
  // cycle wipes history first so only the accepted item is reflected
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky  <= '0;
      res_cnt <= '0;
    end else if (sticky_clr) begin
      sticky  <= acc ? flg : '0;
      res_cnt <= acc ? CNT_W'(1) : '0;
    end else if (acc) begin
      sticky <= sticky | flg;
      if (res_cnt != {CNT_W{1'b1}}) res_cnt <= res_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fp_div_status_stage.sv
// Directed scoreboard bench: expected results are queued on accept and
// checked as each output handshake happens. A second instance runs with
// CANON_NAN=0 and a 2-bit counter on the same stimulus.
module tb_fp_div_status_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        sticky_clr;
  logic [31:0] in1, in2, div_out;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [4:0]  a_out_class;
  logic [3:0]  a_out_flags, a_sticky;
  logic [15:0] a_res_cnt;

  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [4:0]  b_out_class;
  logic [3:0]  b_out_flags, b_sticky;
  logic [1:0]  b_res_cnt;

  fp_div_status_stage #(.CANON_NAN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in1(in1), .in2(in2), .div_out(div_out),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_class(a_out_class), .out_flags(a_out_flags), .sticky(a_sticky),
    .sticky_clr(sticky_clr), .res_cnt(a_res_cnt)
  );

  fp_div_status_stage #(.CANON_NAN(1'b0), .CNT_W(2)) dut_raw (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in1(in1), .in2(in2), .div_out(div_out),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_class(b_out_class), .out_flags(b_out_flags), .sticky(b_sticky),
    .sticky_clr(sticky_clr), .res_cnt(b_res_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d0;
    logic [4:0]  c;
    logic [3:0]  f;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // class constants {nan,inf,normal,sub,zero}; flags {NV,DZ,OF,UF}
  localparam logic [4:0] C_ZERO = 5'b00001, C_SUB = 5'b00010, C_NORM = 5'b00100,
                         C_INF  = 5'b01000, C_NAN = 5'b10000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare head entry whenever an output transfer is about to occur
  always @(negedge clk) begin
    if (rst_n && a_out_valid && out_ready) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_out got=%h want=none", a_out_data);
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("out_data",   a_out_data,          e.d1);
        chk("out_class",  32'(a_out_class),    32'(e.c));
        chk("out_flags",  32'(a_out_flags),    32'(e.f));
        chk("raw_valid",  32'(b_out_valid),    32'd1);
        chk("raw_data",   b_out_data,          e.d0);
        chk("raw_flags",  32'(b_out_flags),    32'(e.f));
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
    in1 = a; in2 = b; div_out = d; in_valid = 1'b1;
  endtask

  // Wait (bounded) for ready, record expectation, let the accept edge pass
  task automatic complete(input exp_t e);
    int t = 0;
    while (!a_in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    total++;
    assert (t < 50) else begin
      bad++;
      $error("FAIL accept_timeout got=%0d want=<50", t);
    end
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                      input exp_t e);
    drive(a, b, d);
    complete(e);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;
    in1 = '0; in2 = '0; div_out = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_in_ready",  32'(a_in_ready),  32'd1);
    chk("rst_out_data",  a_out_data,       32'd0);
    chk("rst_out_class", 32'(a_out_class), 32'd0);
    chk("rst_out_flags", 32'(a_out_flags), 32'd0);
    chk("rst_sticky",    32'(a_sticky),    32'd0);
    chk("rst_res_cnt",   32'(a_res_cnt),   32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: normal quotient, latency 1
    send(32'h3FC00000, 32'h40300000, 32'h3F0BA2E9, '{32'h3F0BA2E9, 32'h3F0BA2E9, C_NORM, 4'b0000});
    chk("t1_out_valid", 32'(a_out_valid), 32'd1);
    chk("t1_out_data",  a_out_data,       32'h3F0BA2E9);
    chk("t1_res_cnt",   32'(a_res_cnt),   32'd1);

    // 2: finite / zero -> inf with DZ
    send(32'hC4FC74CD, 32'h00000000, 32'hFF800000, '{32'hFF800000, 32'hFF800000, C_INF, 4'b0100});
    chk("t2_sticky", 32'(a_sticky), 32'b0100);

    // 3: 0/0 -> NaN canonicalised, NV
    send(32'h00000000, 32'h00000000, 32'hFFC00000, '{32'h7FC00000, 32'hFFC00000, C_NAN, 4'b1000});

    // 4: sNaN divisor -> NV, canonical vs raw NaN
    send(32'h4128A3D7, 32'hFF800001, 32'hFF800001, '{32'h7FC00000, 32'hFF800001, C_NAN, 4'b1000});
    chk("t4_sticky",      32'(a_sticky),  32'b1100);
    chk("t4_res_cnt",     32'(a_res_cnt), 32'd4);
    chk("t4_raw_cnt_sat", 32'(b_res_cnt), 32'd3);
    drain();

    // 5: stalled consumer, three back-to-back items
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 32'h3F800000, '{32'h3F800000, 32'h3F800000, C_NORM, 4'b0000});
    send(32'h00800000, 32'h4B000000, 32'h00000001, '{32'h00000001, 32'h00000001, C_SUB, 4'b0001});
    drive(32'h7F000000, 32'h3E800000, 32'h7F800000);
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_in_ready_full", 32'(a_in_ready),  32'd0);
    chk("t5_head_valid",    32'(a_out_valid), 32'd1);
    chk("t5_head_stable",   a_out_data,       32'h3F800000);
    chk("t5_res_cnt_held",  32'(a_res_cnt),   32'd6);
    out_ready = 1'b1;
    complete('{32'h7F800000, 32'h7F800000, C_INF, 4'b0010});
    chk("t5_res_cnt", 32'(a_res_cnt), 32'd7);
    drain();
    chk("t5_sticky", 32'(a_sticky), 32'b1111);

    // 6a: clear coincident with a DZ accept
    sticky_clr = 1'b1;
    send(32'h3F800000, 32'h80000000, 32'hFF800000, '{32'hFF800000, 32'hFF800000, C_INF, 4'b0100});
    sticky_clr = 1'b0;
    chk("t6_sticky",  32'(a_sticky),  32'b0100);
    chk("t6_res_cnt", 32'(a_res_cnt), 32'd1);
    chk("t6_raw_cnt", 32'(b_res_cnt), 32'd1);
    drain();

    // 6b: reset with two buffered entries discards them
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 32'h3F800000, '{32'h3F800000, 32'h3F800000, C_NORM, 4'b0000});
    send(32'h00000000, 32'h3F800000, 32'h00000000, '{32'h00000000, 32'h00000000, C_ZERO, 4'b0000});
    chk("t6_full_ready", 32'(a_in_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("t6_rst_in_ready",  32'(a_in_ready),  32'd1);
    chk("t6_rst_out_data",  a_out_data,       32'd0);
    chk("t6_rst_res_cnt",   32'(a_res_cnt),   32'd0);
    chk("t6_rst_sticky",    32'(a_sticky),    32'd0);
    q.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // post-reset traffic flows normally
    send(32'h3FC00000, 32'h40300000, 32'h3F0BA2E9, '{32'h3F0BA2E9, 32'h3F0BA2E9, C_NORM, 4'b0000});
    drain();
    chk("post_rst_cnt", 32'(a_res_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
